// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline result, multi-cycle handshake, register file port and status.
interface wb_arbiter_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            pipe_wen;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;

  logic            mc_valid;
  logic            mc_ready;
  logic [4:0]      mc_rd;
  logic [XLEN-1:0] mc_data;

  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            rd_wen;

  logic            pipe_stall;
  logic [CW-1:0]   fifo_count;

  // Result producers and register file observer side
  modport master (
    output pipe_wen, pipe_rd, pipe_data,
    output mc_valid, mc_rd, mc_data,
    input  mc_ready,
    input  rd_addr, rd_data, rd_wen,
    input  pipe_stall, fifo_count
  );

  // Arbiter side
  modport slave (
    input  pipe_wen, pipe_rd, pipe_data,
    input  mc_valid, mc_rd, mc_data,
    output mc_ready,
    output rd_addr, rd_data, rd_wen,
    output pipe_stall, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Merges pipeline writeback and buffered multi-cycle results onto one register file write port.
module wb_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  wb_arbiter_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;

  logic            rd_wen_q;
  logic [4:0]      rd_addr_q;
  logic [XLEN-1:0] rd_data_q;

  logic            fifo_empty;
  logic            ready;
  logic            stall;
  logic            pipe_req;
  logic            push;
  logic            pop;
  logic            take_pipe;
  entry_t          head_entry;

  // Arbitration: a stall forces the FIFO head out; otherwise the pipeline wins
  always_comb begin
    fifo_empty = (count == '0);
    ready      = reset_n && (count < CW'(DEPTH));
    stall      = (starve_cnt == SW'(STARVE_LIMIT));
    pipe_req   = bus.pipe_wen && (bus.pipe_rd != 5'd0);
    push       = bus.mc_valid && ready && (bus.mc_rd != 5'd0);
    pop        = !fifo_empty && (stall || !pipe_req);
    take_pipe  = pipe_req && !pop;
    head_entry = mem[head];
  end

  // Result storage; x0 results are accepted but never written here
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{rd: bus.mc_rd, data: bus.mc_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Counts consecutive arbitration losses of the FIFO head, saturating at the stall threshold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (take_pipe && (starve_cnt < SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Register file write port; address and data hold when no write is issued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_wen_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_wen_q <= take_pipe || pop;
      if (take_pipe) begin
        rd_addr_q <= bus.pipe_rd;
        rd_data_q <= bus.pipe_data;
      end else if (pop) begin
        rd_addr_q <= head_entry.rd;
        rd_data_q <= head_entry.data;
      end
    end
  end

  assign bus.mc_ready   = ready;
  assign bus.pipe_stall = stall;
  assign bus.fifo_count = count;
  assign bus.rd_wen     = rd_wen_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_data    = rd_data_q;

endmodule
